// File: rtl/cpu_io_pkg.sv
// Shared constants and types for the CPU I/O port peripherals.
package cpu_io_pkg;

   localparam int unsigned IO_DATA_W     = 32;
   localparam int unsigned OUTPORT_DEPTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STROBE  = 2'd1,
      ST_RELEASE = 2'd2
   } tx_state_e;

endpackage : cpu_io_pkg

// File: rtl/io_fifo.sv
// Synchronous FIFO with registered occupancy count; full/empty/head are decoded combinationally.
module io_fifo
   import cpu_io_pkg::*;
#(
   parameter int unsigned DATA_W = IO_DATA_W,
   parameter int unsigned DEPTH  = OUTPORT_DEPTH,
   parameter int unsigned CNT_W  = 3
)(
   input  logic              clk_i,
   input  logic              clear_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_c,
   output logic              full_c,
   output logic              empty_c,
   output logic [CNT_W-1:0]  count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
      count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
   end

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; a clear only invalidates it via the pointers.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_c = mem_q[rd_ptr_q];
   assign full_c  = (count_q == CNT_W'(DEPTH));
   assign empty_c = (count_q == '0);
   assign count_o = count_q;

endmodule : io_fifo

// File: rtl/out_port_hs.sv
// Buffered output port: FIFO of CPU writes drained by a four-phase Out_Strobe/Out_Ack handshake.
// Define OUTPORT_TIMEOUT_EN to add an ack-wait timeout that discards the word and sets out_err.
module out_port_hs
   import cpu_io_pkg::*;
#(
   parameter int unsigned DATA_W      = IO_DATA_W,
   parameter int unsigned DEPTH       = OUTPORT_DEPTH,
   parameter int unsigned CNT_W       = 3
`ifdef OUTPORT_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYC = 255
`endif
)(
   input  logic              clock,
   input  logic              clear,
   input  logic [DATA_W-1:0] BusMuxOut,
   input  logic              OutPortin,
   output logic [DATA_W-1:0] Outport_Out,
   output logic              Out_Strobe,
   input  logic              Out_Ack,
   output logic              out_full,
   output logic              out_empty,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf,
   output logic              out_err
);

   tx_state_e         state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              strobe_q, strobe_d;
   logic              ovf_q, ovf_d;
   logic              pop_c;
   logic              push_c;
   logic [DATA_W-1:0] head_c;
   logic              full_c;
   logic              empty_c;

`ifdef OUTPORT_TIMEOUT_EN
   localparam int unsigned WAIT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [WAIT_W-1:0] wait_inc_c;
   logic              err_q, err_d;

   assign wait_inc_c = wait_q + WAIT_W'(1);
`endif

   // A push into a full FIFO still fits if the head leaves on the same edge.
   assign push_c = OutPortin & (~full_c | pop_c);
   assign ovf_d  = ovf_q | (OutPortin & ~push_c);

   io_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) u_fifo (
      .clk_i   (clock),
      .clear_i (clear),
      .push_i  (push_c),
      .pop_i   (pop_c),
      .wdata_i (BusMuxOut),
      .rdata_c (head_c),
      .full_c  (full_c),
      .empty_c (empty_c),
      .count_o (out_count)
   );

   // Transmit FSM next-state and output decode.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      strobe_d = strobe_q;
      pop_c    = 1'b0;
`ifdef OUTPORT_TIMEOUT_EN
      wait_d   = wait_q;
      err_d    = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!empty_c) begin
               data_d   = head_c;
               strobe_d = 1'b1;
               state_d  = ST_STROBE;
`ifdef OUTPORT_TIMEOUT_EN
               wait_d   = '0;
`endif
            end
         end
         ST_STROBE: begin
`ifdef OUTPORT_TIMEOUT_EN
            wait_d = wait_inc_c;
`endif
            if (Out_Ack) begin
               pop_c    = 1'b1;
               strobe_d = 1'b0;
               state_d  = ST_RELEASE;
            end
`ifdef OUTPORT_TIMEOUT_EN
            else if (wait_inc_c == WAIT_W'(TIMEOUT_CYC)) begin
               pop_c    = 1'b1;
               strobe_d = 1'b0;
               err_d    = 1'b1;
               state_d  = ST_IDLE;
            end
`endif
         end
         ST_RELEASE: begin
            strobe_d = 1'b0;
            if (!Out_Ack) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            strobe_d = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q  <= ST_IDLE;
         data_q   <= '0;
         strobe_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         strobe_q <= strobe_d;
         ovf_q    <= ovf_d;
      end
   end

`ifdef OUTPORT_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (clear) begin
         wait_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wait_q <= wait_d;
         err_q  <= err_d;
      end
   end

   assign out_err = err_q;
`else
   assign out_err = 1'b0;
`endif

   assign Outport_Out = data_q;
   assign Out_Strobe  = strobe_q;
   assign out_ovf     = ovf_q;
   assign out_full    = full_c;
   assign out_empty   = empty_c;

endmodule : out_port_hs

// File: tb/tb_out_port_hs.sv
// Scoreboard bench for out_port_hs: queued expected words are checked as the device handshake sees them.
module tb_out_port_hs;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] BusMuxOut;
   logic        OutPortin;
   logic [31:0] Outport_Out;
   logic        Out_Strobe;
   logic        Out_Ack;
   logic        out_full;
   logic        out_empty;
   logic [2:0]  out_count;
   logic        out_ovf;
   logic        out_err;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] sb [$];
   int          mdl_occ = 0;
   logic        exp_ovf = 1'b0;
   int          pulses = 0;
   logic        strobe_prev = 1'b0;

   always #5 clock = ~clock;

   out_port_hs #(
      .DATA_W (32),
      .DEPTH  (4),
      .CNT_W  (3)
`ifdef OUTPORT_TIMEOUT_EN
      , .TIMEOUT_CYC (10)
`endif
   ) dut (
      .clock       (clock),
      .clear       (clear),
      .BusMuxOut   (BusMuxOut),
      .OutPortin   (OutPortin),
      .Outport_Out (Outport_Out),
      .Out_Strobe  (Out_Strobe),
      .Out_Ack     (Out_Ack),
      .out_full    (out_full),
      .out_empty   (out_empty),
      .out_count   (out_count),
      .out_ovf     (out_ovf),
      .out_err     (out_err)
   );

   always @(negedge clock) begin
      if (Out_Strobe && !strobe_prev) pulses++;
      strobe_prev = Out_Strobe;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      BusMuxOut = w;
      OutPortin = 1'b1;
      if (mdl_occ < 4) begin
         sb.push_back(w);
         mdl_occ++;
      end else begin
         exp_ovf = 1'b1;
      end
      tick();
      OutPortin = 1'b0;
      chk("push_count", 32'(out_count), 32'(mdl_occ));
      chk("push_ovf", 32'(out_ovf), 32'(exp_ovf));
   endtask

   // Device model: wait for Strobe, check the word, ack after dly cycles, release.
   task automatic serve(input int dly);
      int          n;
      logic [31:0] w;
      n = 0;
      while (Out_Strobe !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      if (Out_Strobe !== 1'b1) begin
         chk("strobe_wait", 32'(Out_Strobe), 32'd1);
         return;
      end
      if (sb.size() == 0) begin
         chk("sb_underflow", 32'(sb.size()), 32'd1);
         return;
      end
      w = sb.pop_front();
      chk("deliver", Outport_Out, w);
      repeat (dly) tick();
      Out_Ack = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (Out_Strobe === 1'b1 && n < 100);
      chk("strobe_drop", 32'(Out_Strobe), 32'd0);
      mdl_occ--;
      Out_Ack = 1'b0;
      tick();
      chk("hold_data", Outport_Out, w);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      sb.delete();
      mdl_occ = 0;
      exp_ovf = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          p0;
      int          n;
      logic [31:0] w;

      clear     = 1'b1;
      BusMuxOut = '0;
      OutPortin = 1'b0;
      Out_Ack   = 1'b0;
      tick();
      do_clear();
      chk("rst_strobe", 32'(Out_Strobe), 32'd0);
      chk("rst_data", Outport_Out, 32'd0);
      chk("rst_empty", 32'(out_empty), 32'd1);
      chk("rst_full", 32'(out_full), 32'd0);
      chk("rst_count", 32'(out_count), 32'd0);
      chk("rst_ovf", 32'(out_ovf), 32'd0);
      chk("rst_err", 32'(out_err), 32'd0);

      // Single word, ack two cycles after Strobe.
      p0 = pulses;
      push_word(32'h0000_00A5);
      chk("lat_n", 32'(Out_Strobe), 32'd0);
      tick();
      chk("lat_n1", 32'(Out_Strobe), 32'd1);
      serve(2);
      repeat (3) tick();
      chk("single_pulses", 32'(pulses - p0), 32'd1);
      chk("single_empty", 32'(out_empty), 32'd1);
      chk("single_hold", Outport_Out, 32'h0000_00A5);

      // Burst of five with the device stalled.
      for (int i = 1; i <= 5; i++) begin
         push_word(32'(i * 'h11));
         if (i == 4) chk("burst_full", 32'(out_full), 32'd1);
      end
      chk("burst_ovf", 32'(out_ovf), 32'd1);

      // Pop of the full FIFO coincides with a push of 0x66.
      chk("pp_strobe", 32'(Out_Strobe), 32'd1);
      w = sb.pop_front();
      chk("pp_head", Outport_Out, w);
      Out_Ack   = 1'b1;
      OutPortin = 1'b1;
      BusMuxOut = 32'h66;
      sb.push_back(32'h66);
      tick();
      OutPortin = 1'b0;
      Out_Ack   = 1'b0;
      chk("pp_count", 32'(out_count), 32'd4);
      chk("pp_strobe_low", 32'(Out_Strobe), 32'd0);
      chk("pp_ovf", 32'(out_ovf), 32'd1);
      tick();
      repeat (4) serve(0);
      chk("burst_empty", 32'(out_empty), 32'd1);
      chk("burst_sb", 32'(sb.size()), 32'd0);

      // Clear while in STROBE with three words queued.
      push_word(32'h91);
      push_word(32'h92);
      push_word(32'h93);
      chk("clr_pre_strobe", 32'(Out_Strobe), 32'd1);
      do_clear();
      chk("clr_strobe", 32'(Out_Strobe), 32'd0);
      chk("clr_data", Outport_Out, 32'd0);
      chk("clr_count", 32'(out_count), 32'd0);
      chk("clr_ovf", 32'(out_ovf), 32'd0);
      Out_Ack = 1'b1;
      tick();
      Out_Ack = 1'b0;
      repeat (3) tick();
      chk("clr_ack_strobe", 32'(Out_Strobe), 32'd0);
      chk("clr_ack_count", 32'(out_count), 32'd0);
      chk("clr_ack_data", Outport_Out, 32'd0);

      // Ack held high from reset.
      Out_Ack = 1'b1;
      do_clear();
      tick();
      push_word(32'h77);
      tick();
      chk("hi_strobe", 32'(Out_Strobe), 32'd1);
      chk("hi_data", Outport_Out, sb.pop_front());
      tick();
      mdl_occ--;
      chk("hi_pop_strobe", 32'(Out_Strobe), 32'd0);
      chk("hi_pop_count", 32'(out_count), 32'd0);
      repeat (3) tick();
      push_word(32'h78);
      repeat (4) tick();
      chk("hi_stall_strobe", 32'(Out_Strobe), 32'd0);
      chk("hi_stall_count", 32'(out_count), 32'd1);
      Out_Ack = 1'b0;
      serve(1);
      chk("hi_empty", 32'(out_empty), 32'd1);
      chk("err_default", 32'(out_err), 32'd0);

`ifdef OUTPORT_TIMEOUT_EN
      // Device never answers: word discarded after the timeout.
      push_word(32'h88);
      tick();
      chk("to_data", Outport_Out, sb.pop_front());
      n = 0;
      while (Out_Strobe === 1'b1 && n < 50) begin
         n++;
         tick();
      end
      mdl_occ--;
      chk("to_len", 32'(n), 32'd10);
      chk("to_err", 32'(out_err), 32'd1);
      chk("to_empty", 32'(out_empty), 32'd1);
      push_word(32'h99);
      serve(1);
      chk("to_err_sticky", 32'(out_err), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_out_port_hs

// File: doc/out_port_hs.md
Name: out_port_hs

Overview:
- Output-port peripheral for the CPU datapath; the transmit-side counterpart of the strobed input port.
- An "out Ra" instruction asserts OutPortin while the selected register drives BusMuxOut. The word is pushed into a small FIFO.
- A transmit FSM delivers each word to the external device using a four-phase Out_Strobe/Out_Ack handshake, so the CPU never stalls on a slow device.

Parameters:
- DATA_W, 32, bus and port data width
- DEPTH, 4, FIFO entries; power of two, at least 2
- CNT_W, 3, width of out_count; equals log2(DEPTH)+1
- TIMEOUT_CYC, 255, ack-wait limit in cycles; used only when OUTPORT_TIMEOUT_EN is defined

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  synchronous active-high reset
- BusMuxOut  in  DATA_W  datapath bus
- OutPortin  in  1  push BusMuxOut into the FIFO at this edge
- Outport_Out  out  DATA_W  registered data to the external device
- Out_Strobe  out  1  data-valid request to the device
- Out_Ack  in  1  device acknowledge; treated as already synchronous
- out_full  out  1  FIFO holds DEPTH words
- out_empty  out  1  FIFO holds 0 words
- out_count  out  CNT_W  current FIFO occupancy
- out_ovf  out  1  sticky: a push was dropped
- out_err  out  1  sticky: a word timed out (0 when the macro is undefined)

Behaviour:
- Reset (clear=1 at a rising edge):
  - Pointers and count go to 0; out_empty=1, out_full=0.
  - Outport_Out=0, Out_Strobe=0, out_ovf=0, out_err=0.
  - State goes to IDLE.
  - This applies mid-handshake too: Strobe drops on that edge and queued words are discarded.
- Push rule:
  - Accepted when OutPortin=1 and (!out_full, or a pop happens in the same cycle).
  - Otherwise the word is dropped, out_ovf is set, and FIFO contents are unchanged.
- Pop rule: a pop happens exactly on the STROBE→RELEASE transition.
- Count rule: out_count = previous count + push − pop; a simultaneous push and pop leaves it unchanged.
- Pointers wrap modulo DEPTH.
- FSM states: IDLE, STROBE, RELEASE.
  - IDLE: if !out_empty, load the head word into Outport_Out, set Out_Strobe=1, go to STROBE. Otherwise stay.
  - STROBE: hold Outport_Out and Out_Strobe=1. When Out_Ack=1: pop, set Out_Strobe=0, go to RELEASE.
  - RELEASE: hold Out_Strobe=0. When Out_Ack=0, go to IDLE. Out_Ack stuck high stalls here indefinitely.
- Outport_Out holds the last delivered word after the handshake until the next IDLE→STROBE load.
- Latency: push at edge N into an empty FIFO with the FSM in IDLE gives Out_Strobe=1 and valid data after edge N+1.
- Throughput: at best one word per 3 cycles with an immediately responding device.
- Out_Ack=1 while in IDLE is ignored; no load happens until the FSM reaches STROBE.
- A push in the same cycle as the IDLE check on an empty FIFO is not seen until the next cycle; there is no bypass.
- All outputs are registered except out_full, out_empty and out_count, which are decoded from the count register.

Optional Feature:
- Macro: OUTPORT_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider wait counter clears on entry to STROBE and increments each cycle in STROBE while Out_Ack=0.
  - When the counter reaches TIMEOUT_CYC: pop (discard the word), set Out_Strobe=0, set out_err, go to IDLE.
  - Out_Ack arriving on the same cycle as the timeout takes priority as a normal ack: go to RELEASE, out_err stays unchanged.
- Undefined: no counter exists, STROBE waits indefinitely, and out_err is tied to 0.

Decomposition:
- Shared package cpu_io_pkg holds:
  - the FSM state enum (IDLE=2'd0, STROBE=2'd1, RELEASE=2'd2);
  - DATA_W default;
  - a shared OUTPORT_DEPTH constant.
- One natural sub-module, io_fifo: parameterized synchronous FIFO with push, pop, data, full, empty and count. Its overflow decision stays in out_port_hs.

Test Plan:
- Single word, device acks 2 cycles after Strobe and releases 1 cycle later → exactly one Strobe pulse, and Outport_Out=0x000000A5 on the push of 0x000000A5. Afterwards out_empty=1 and Outport_Out still reads 0x000000A5.
- Burst of 5 pushes (0x11..0x55) on consecutive cycles while the device holds Out_Ack=0 → out_full=1 after 4 pushes; 0x55 is dropped and out_ovf=1. Releasing the device then delivers 0x11, 0x22, 0x33, 0x44 in order.
- Full FIFO during a STROBE→RELEASE pop, plus a simultaneous push of 0x66 → push accepted, out_count stays 4, out_ovf unchanged.
- clear asserted while in STROBE with 3 words queued → next edge: Out_Strobe=0, Outport_Out=0, out_count=0, state IDLE. A later Out_Ack pulse has no effect.
- Out_Ack held high from reset, then one push of 0x77 → Strobe rises, and the pop happens on the first STROBE cycle. The FSM stalls in RELEASE until Out_Ack falls, then returns to IDLE.
- With OUTPORT_TIMEOUT_EN and TIMEOUT_CYC=10, push 0x88 with Out_Ack never asserted → Strobe stays high for 10 cycles then drops; out_err=1, out_empty=1. The next queued word is presented normally.
